// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryption core: one cipher round per clock.
// Byte order follows FIPS-197 hex strings: byte 0 sits in the MSBs of every
// 128-bit bus (bits [127:120]) and the state is column-major, so byte k is
// row k%4, column k/4.

package aes_pkg;

  // Forward S-box, entry 0 in the leftmost byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255 - int'(b)) +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// SubBytes: S-box applied to each of the 16 state bytes.
module aes_sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  // Byte-wise substitution.
  always_comb begin
    // NOTE: every output bit is given a value before the loop, so no latch can be inferred.
    o_state = '0;
    for (int k = 0; k < 16; k++) begin
      o_state[127-8*k -: 8] = sbox(i_state[127-8*k -: 8]);
    end
  end

endmodule

// ShiftRows: row r rotates left by r columns.
module aes_shift_rows (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  // Byte (r,c) takes byte (r,(c+r)%4).
  always_comb begin
    o_state = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o_state[127-8*(r+4*c) -: 8] = i_state[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
  end

endmodule

// MixColumns: each column multiplied by the circulant {02,03,01,01}.
module aes_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  // Column-wise GF(2^8) matrix multiply.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    o_state = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = i_state[127-32*c -: 8];
      a1 = i_state[119-32*c -: 8];
      a2 = i_state[111-32*c -: 8];
      a3 = i_state[103-32*c -: 8];
      o_state[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o_state[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o_state[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o_state[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

endmodule

// AddRoundKey: 128-bit XOR with the round key.
module aes_add_round_key (
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  output logic [127:0] o_state
);

  assign o_state = i_state ^ i_round_key;

endmodule

// KeyExpansion: all Nr+1 round keys, round 0 in the MSBs.
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic [Nk*32-1:0]      i_key,
  output logic [128*(Nr+1)-1:0] o_round_keys
);

  localparam int NW = 4 * (Nr + 1);

  // Word schedule w[0..NW-1], packed word 0 first.
  always_comb begin
    logic [31:0] words [NW];
    logic [31:0] temp;
    logic [7:0]  rcon;
    temp = '0;
    rcon = 8'h01;
    o_round_keys = '0;
    for (int i = 0; i < NW; i++) begin
      words[i] = '0;
    end
    for (int i = 0; i < Nk; i++) begin
      words[i] = i_key[Nk*32-1-32*i -: 32];
    end
    for (int i = Nk; i < NW; i++) begin
      temp = words[i-1];
      if (i % Nk == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end else if (Nk > 6 && i % Nk == 4) begin
        temp = sub_word(temp);
      end
      words[i] = words[i-Nk] ^ temp;
    end
    for (int i = 0; i < NW; i++) begin
      o_round_keys[NW*32-1-32*i -: 32] = words[i];
    end
  end

endmodule

// Top: one shared round datapath, a round counter and a 3-state control FSM.
module aes_encrypt_iter #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in,
  input  logic [Nk*32-1:0]  key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      encrypted
);

  localparam int RW = $clog2(Nr + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_t;

  fsm_t             r_fsm;
  logic [127:0]     r_state;
  logic [Nk*32-1:0] r_key_q;
  logic [RW-1:0]    r_rnd;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [128*(Nr+1)-1:0] w_round_keys;
  logic [127:0]          w_rk;
  logic [127:0]          w_sub;
  logic [127:0]          w_shift;
  logic [127:0]          w_mix;
  logic [127:0]          w_round_mid;
  logic [127:0]          w_round_last;

  aes_key_expansion #(.Nk(Nk), .Nr(Nr)) u_key_exp (
    .i_key        (r_key_q),
    .o_round_keys (w_round_keys)
  );

  // Pick round key rk(rnd) out of the expanded schedule.
  always_comb begin
    w_rk = '0;
    for (int r = 0; r <= Nr; r++) begin
      if (r_rnd == RW'(r)) begin
        w_rk = w_round_keys[128*(Nr+1)-1-128*r -: 128];
      end
    end
  end

  aes_sub_bytes u_sub (
    .i_state (r_state),
    .o_state (w_sub)
  );

  aes_shift_rows u_shift (
    .i_state (w_sub),
    .o_state (w_shift)
  );

  aes_mix_columns u_mix (
    .i_state (w_shift),
    .o_state (w_mix)
  );

  aes_add_round_key u_ark_mid (
    .i_state     (w_mix),
    .i_round_key (w_rk),
    .o_state     (w_round_mid)
  );

  // The last round skips MixColumns.
  aes_add_round_key u_ark_last (
    .i_state     (w_shift),
    .i_round_key (w_rk),
    .o_state     (w_round_last)
  );

  // Control FSM with registered handshake outputs and the round datapath state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      // NOTE: state and key are plain flops, not a RAM, so clearing them here is cheap and keeps a discarded block from ever showing on encrypted.
      r_state     <= '0;
      r_key_q     <= '0;
      r_rnd       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here updates from pre-edge values.
      case (r_fsm)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_key_q    <= key;
            // Round-0 key comes straight from the port; key_q is not loaded yet.
            r_state    <= in ^ key[Nk*32-1 -: 128];
            r_rnd      <= RW'(1);
            r_in_ready <= 1'b0;
            r_fsm      <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (r_rnd < RW'(Nr)) begin
            r_state <= w_round_mid;
            r_rnd   <= r_rnd + RW'(1);
          end else begin
            r_state     <= w_round_last;
            r_out_valid <= 1'b1;
            r_fsm       <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_fsm       <= S_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_fsm       <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign encrypted = r_state;

endmodule
